// File: rtl/fe_packet_buffer.sv
// FE receive buffer: packs 16-bit samples into 256-bit words and stores whole packets in a ping-pong RAM.
// Optional per-packet timestamp (sample 1) is built when FE_BUF_TIMESTAMP_EN is defined.
module fe_packet_buffer #(
  parameter int PKT_WORDS  = 125,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_sop,
  input  logic                  rx_eop,
  output logic                  buf_data_ready,
  input  logic                  rd_req,
  output logic [255:0]          rd_data,
  output logic [15:0]           pkt_timestamp,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [DROP_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DISCARD = 2'd2} wr_state_t;

  localparam logic [6:0] LAST_PTR = 7'(PKT_WORDS - 1);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [255:0] ram [0:1][0:127];

  wr_state_t    state;
  logic         wr_bank;
  logic [6:0]   wr_ptr;
  logic [3:0]   samp_idx;
  logic [255:16] word_buf;
  logic         wr_en;
  logic         wr_sel;
  logic [6:0]   wr_addr;
  logic [255:0] wr_word;
  logic         cmpl;
  logic         cmpl_bank;

  logic [1:0]   full;
  logic         rd_bank;
  logic [6:0]   rd_ptr;
  logic [1:0]   full_nx;
  logic         rd_bank_nx;
  logic [6:0]   rd_ptr_nx;
  logic         last_samp;

  assign last_samp = (wr_ptr == LAST_PTR) && (samp_idx == 4'd15);

  // write-side packet FSM: packing, word commit, completion and error/drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      wr_ptr    <= 7'd0;
      samp_idx  <= 4'd0;
      word_buf  <= '0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= 7'd0;
      wr_word   <= 256'd0;
      cmpl      <= 1'b0;
      cmpl_bank <= 1'b0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      wr_en <= 1'b0;
      cmpl  <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_sop) begin
              if (full[wr_bank]) begin
                drop_cnt <= sat_inc(drop_cnt);
                state    <= rx_eop ? IDLE : DISCARD;
              end else if (rx_eop) begin
                err_cnt <= sat_inc(err_cnt);
              end else begin
                word_buf[255:240] <= rx_data;
                samp_idx <= 4'd1;
                wr_ptr   <= 7'd0;
                state    <= FILL;
              end
            end
          end
          FILL: begin
            if (rx_sop) begin
              // a new sop restarts the fill with this sample as sample 0
              err_cnt <= sat_inc(err_cnt);
              word_buf[255:240] <= rx_data;
              samp_idx <= 4'd1;
              wr_ptr   <= 7'd0;
              state    <= rx_eop ? IDLE : FILL;
            end else if (last_samp) begin
              if (rx_eop) begin
                wr_en     <= 1'b1;
                wr_sel    <= wr_bank;
                wr_addr   <= wr_ptr;
                wr_word   <= {word_buf, rx_data};
                cmpl      <= 1'b1;
                cmpl_bank <= wr_bank;
                wr_bank   <= ~wr_bank;
                wr_ptr    <= 7'd0;
                samp_idx  <= 4'd0;
                state     <= IDLE;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                state   <= DISCARD;
              end
            end else if (rx_eop) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= IDLE;
            end else begin
              for (int k = 0; k < 15; k++) begin
                if (samp_idx == 4'(k)) word_buf[255-16*k -: 16] <= rx_data;
              end
              samp_idx <= samp_idx + 4'd1;
              if (samp_idx == 4'd15) begin
                wr_en   <= 1'b1;
                wr_sel  <= wr_bank;
                wr_addr <= wr_ptr;
                wr_word <= {word_buf, rx_data};
                wr_ptr  <= wr_ptr + 7'd1;
              end
            end
          end
          DISCARD: begin
            if (rx_eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // packet RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_sel][wr_addr] <= wr_word;
  end

`ifdef FE_BUF_TIMESTAMP_EN
  logic [15:0] ts_bank [0:1];
  logic        ts_cap;

  assign ts_cap = rx_valid && (state == FILL) && !rx_sop && !rx_eop &&
                  (wr_ptr == 7'd0) && (samp_idx == 4'd1);

  // per-bank timestamp latch (sample 1 of the packet)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_bank[0] <= 16'd0;
      ts_bank[1] <= 16'd0;
    end else if (ts_cap) begin
      ts_bank[wr_bank] <= rx_data;
    end
  end
`endif

  // read-side next state: completion sets a flag, the final pop clears and swaps banks
  always_comb begin
    full_nx    = full;
    rd_bank_nx = rd_bank;
    rd_ptr_nx  = rd_ptr;
    if (cmpl) begin
      full_nx[cmpl_bank] = 1'b1;
    end else begin
      full_nx = full;
    end
    if (rd_req && full[rd_bank]) begin
      if (rd_ptr == LAST_PTR) begin
        full_nx[rd_bank] = 1'b0;
        rd_bank_nx       = ~rd_bank;
        rd_ptr_nx        = 7'd0;
      end else begin
        rd_ptr_nx = rd_ptr + 7'd1;
      end
    end else begin
      rd_ptr_nx = rd_ptr;
    end
  end

  // read-side registers and show-ahead outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full           <= 2'b00;
      rd_bank        <= 1'b0;
      rd_ptr         <= 7'd0;
      buf_data_ready <= 1'b0;
      rd_data        <= 256'd0;
      pkt_timestamp  <= 16'd0;
    end else begin
      full           <= full_nx;
      rd_bank        <= rd_bank_nx;
      rd_ptr         <= rd_ptr_nx;
      buf_data_ready <= full_nx[rd_bank_nx];
      rd_data        <= ram[rd_bank_nx][rd_ptr_nx];
`ifdef FE_BUF_TIMESTAMP_EN
      pkt_timestamp  <= full_nx[rd_bank_nx] ? ts_bank[rd_bank_nx] : 16'd0;
`else
      pkt_timestamp  <= 16'd0;
`endif
    end
  end

endmodule

// File: doc/fe_packet_buffer.md
# fe_packet_buffer

Per-board receive buffer between one front-end (FE) serial link deserializer and the DRAM write-address generator. Packs incoming 16-bit FE samples into 256-bit DRAM words and stores complete packets in a two-bank ping-pong RAM. Raises a ready flag for each complete packet and serves show-ahead, one-word-per-request reads to the downstream DRAM writer. Eight instances exist, one per board; their ready flags form the arbiter's 8-bit ready mask.

## Interface
Parameters:
- PKT_WORDS, 125, number of 256-bit words per FE packet (16·PKT_WORDS samples); legal range 2..128
- DROP_CNT_W, 16, width of the saturating drop and error counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  16  FE sample
- rx_valid  in  1  rx_data valid this cycle
- rx_sop  in  1  first sample of a packet; qualified by rx_valid
- rx_eop  in  1  last sample of a packet; qualified by rx_valid
- buf_data_ready  out  1  a complete packet is available at the read head
- rd_req  in  1  pop the head word; ignored while buf_data_ready=0
- rd_data  out  256  head word (show-ahead)
- pkt_timestamp  out  16  timestamp of the head packet
- drop_cnt  out  DROP_CNT_W  packets dropped because both banks were full (saturating)
- err_cnt  out  DROP_CNT_W  malformed packets discarded (saturating)

## Operation
- RAM: 2 banks × 128 × 256 bit. Write side owns `wr_bank`; read side owns `rd_bank`. Each bank has a `full` flag.
- Packing: sample k of a word goes to bits [255-16k -: 16]. The first sample lands in [255:240] and the second sample (the timestamp) lands in [239:224]. After the 16th sample the word is written at `wr_ptr`, and `wr_ptr` increments.
- Write FSM:
  - IDLE: on rx_valid & rx_sop, go to FILL if `full[wr_bank]`=0. Otherwise go to DISCARD and increment drop_cnt. Samples that arrive without sop are ignored silently.
  - FILL: accept each valid sample.
    - On eop with exactly 16·PKT_WORDS samples accepted: set `full[wr_bank]`, toggle `wr_bank`, reset the pointers, go to IDLE.
    - Early eop: discard the packet, increment err_cnt, go to IDLE.
    - Sample count reaches 16·PKT_WORDS without eop: discard the packet, increment err_cnt, go to DISCARD.
    - rx_sop while in FILL: discard the partial packet, increment err_cnt, and restart FILL with this sample as sample 0.
    - Discarding a partial packet leaves `full` untouched and does not toggle the bank.
  - DISCARD: drop samples until rx_valid & rx_eop, then go to IDLE.
- Read side:
  - buf_data_ready = `full[rd_bank]`.
  - rd_req while ready: increment `rd_ptr`.
  - On the PKT_WORDS-th pop: clear `full[rd_bank]`, toggle `rd_bank`, set `rd_ptr` to 0.
- Counters saturate at all-ones.

## Timing
- Reset value of every output is 0. All banks empty; `wr_bank`=`rd_bank`=0; FSM in IDLE.
- Reset mid-packet or mid-read discards all buffered data.
- Sample 16 of a word accepted at cycle N: RAM write at N+1.
- eop of a good packet at cycle N: buf_data_ready=1 at N+2, with rd_data = word 0 and pkt_timestamp valid in the same cycle.
- Show-ahead read: rd_req sampled high at cycle N → rd_data shows the next word at N+1. Back-to-back rd_req every cycle is supported.
- After the last pop at cycle N:
  - buf_data_ready falls at N+1 if the other bank is empty.
  - If the other bank is full, buf_data_ready stays high and rd_data = that bank's word 0 at N+1.
- Packet completing into bank B in the same cycle as the last pop of bank A: both events take effect, and the ready flag does not glitch low.
- A bank freed at cycle N accepts a new sop at N+1.
- drop_cnt and err_cnt update one cycle after the causing sample.

## Configuration
- FE_BUF_TIMESTAMP_EN defined: sample 1 of each packet is latched per bank, and pkt_timestamp presents the head bank's value while buf_data_ready=1.
- Not defined: pkt_timestamp is tied to 0 and no timestamp registers are built.

## Test plan
- Single packet (PKT_WORDS=125), samples 0..1999 with sop/eop → buf_data_ready at eop+2; rd_data[255:240]=0, rd_data[239:224]=1; 125 pops drain it; ready falls; drop_cnt=err_cnt=0.
- Three back-to-back packets with no reads → packets 1 and 2 buffered, packet 3 dropped (drop_cnt=1). Draining yields packet 1 then packet 2 with ready held high continuously across the bank switch.
- eop after 1000 samples, then a good packet → err_cnt=1; only the good packet is read out; its word 0 = sample 0 of the good packet.
- rx_sop at sample 500 of a packet → err_cnt=1; the new packet is stored intact from the second sop.
- rd_req asserted while buf_data_ready=0 → no pointer movement; a later packet reads out from word 0. With FE_BUF_TIMESTAMP_EN, pkt_timestamp equals the packet's second sample (e.g. 0x1234).
- rst pulsed during the 60th read pop → all outputs 0 asynchronously; the next full packet reads out correctly from bank 0.
